fazyrv_spm_ser: RTL and testbench

- Parallel-in, serial-out scratchpad; the counterpart of the serial-in address/data scratchpads.
- Captures a 32-bit word through a valid/ready load handshake.
- Emits the word LSB-chunk first, CHUNKSIZE bits per shift, into the chunked datapath (e.g. load data or CSR read values entering the serial core).
- Tracks chunk position internally and flags the last chunk and completion.

---
 rtl/fazyrv_spm_ser_pkg.sv | 25 ++
 rtl/fazyrv_spm_ser_if.sv | 26 ++
 rtl/fazyrv_spm_ser.sv | 98 +++++++++
 tb/tb_fazyrv_spm_ser.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fazyrv_spm_ser_pkg.sv
// Shared types and helpers for the FazyRV scratchpads (serial-in and parallel-in).
// Holds the state encoding, the CHUNKSIZE legality check, the chunk-count helper and the debug struct.
package fazyrv_spm_pkg;

  typedef enum logic {
    SPM_IDLE  = 1'b0,
    SPM_SHIFT = 1'b1
  } spm_state_e;

  // The debug counter is sized for the worst case (CHUNKSIZE=1, 32 chunks).
  typedef struct packed {
    spm_state_e  state;
    logic [4:0]  cnt;
    logic [31:0] shreg;
  } spm_dbg_t;

  function automatic bit spm_chunk_legal(input int cs);
    return (cs == 1) || (cs == 2) || (cs == 4) || (cs == 8);
  endfunction

  function automatic int spm_nchunks(input int cs);
    return 32 / cs;
  endfunction

endpackage

// File: rtl/fazyrv_spm_ser_if.sv
// Load/serial port bundle of the parallel-in, serial-out scratchpad.
// Load handshake: a word transfers on a rising clock edge where ld_valid_i && ld_ready_o;
// the producer must hold ld_valid_i/ld_data_i stable until that edge. shft_i consumes ser_o
// on every edge where it is high while ser_valid_o is high.
interface fazyrv_spm_ser_if #(
  parameter int CHUNKSIZE = 2
);
  logic                 ld_valid_i;
  logic [31:0]          ld_data_i;
  logic                 ld_ready_o;
  logic                 shft_i;
  logic [CHUNKSIZE-1:0] ser_o;
  logic                 ser_valid_o;
  logic                 last_o;
  logic                 done_o;

  modport master (
    output ld_valid_i, ld_data_i, shft_i,
    input  ld_ready_o, ser_o, ser_valid_o, last_o, done_o
  );

  modport slave (
    input  ld_valid_i, ld_data_i, shft_i,
    output ld_ready_o, ser_o, ser_valid_o, last_o, done_o
  );
endinterface

// File: rtl/fazyrv_spm_ser.sv
// Parallel-in, serial-out scratchpad: captures a 32-bit word and streams it LSB chunk first.
// Define FAZYRV_SPM_SER_SEXT_EN to refill the register with the word's sign bit instead of zeros.
module fazyrv_spm_ser
  import fazyrv_spm_pkg::*;
#(
  parameter int CHUNKSIZE = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_in,
  fazyrv_spm_ser_if.slave         bus,
  output spm_dbg_t                dbg_o
);

  localparam int NCHUNKS = spm_nchunks(CHUNKSIZE);
  localparam int CW      = (NCHUNKS > 2) ? $clog2(NCHUNKS) : 1;

  if (!spm_chunk_legal(CHUNKSIZE)) begin : g_bad_chunksize
    $error("fazyrv_spm_ser: CHUNKSIZE must be 1, 2, 4 or 8");
  end

  spm_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [31:0]          shreg_q;
  logic                 done_q;
  logic [CHUNKSIZE-1:0] fill;
  logic                 last;
  logic                 fin;
  logic                 ld_ready;
  logic                 load;

`ifdef FAZYRV_SPM_SER_SEXT_EN
  logic sign_q;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      sign_q <= 1'b0;
    end else if (load) begin
      sign_q <= bus.ld_data_i[31];
    end
  end

  assign fill = {CHUNKSIZE{sign_q}};
`else
  assign fill = '0;
`endif

  // Final chunk consumed; this is also the only SHIFT cycle that accepts a new word.
  assign last     = (state_q == SPM_SHIFT) && (cnt_q == CW'(NCHUNKS - 1));
  assign fin      = last && bus.shft_i;
  assign ld_ready = (state_q == SPM_IDLE) || fin;
  assign load     = ld_ready && bus.ld_valid_i;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= SPM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SPM_IDLE:  if (bus.ld_valid_i) state_d = SPM_SHIFT;
      SPM_SHIFT: if (fin)            state_d = load ? SPM_SHIFT : SPM_IDLE;
      default:                       state_d = SPM_IDLE;
    endcase
  end

  always_comb begin
    bus.ld_ready_o  = ld_ready;
    bus.ser_valid_o = (state_q == SPM_SHIFT);
    bus.ser_o       = shreg_q[CHUNKSIZE-1:0];
    bus.last_o      = last;
    bus.done_o      = done_q;
  end

  // The final shift still happens so the residual register reflects the fill value.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= fin;
      if (load) begin
        shreg_q <= bus.ld_data_i;
        cnt_q   <= '0;
      end else if ((state_q == SPM_SHIFT) && bus.shft_i) begin
        shreg_q <= {fill, shreg_q[31:CHUNKSIZE]};
        cnt_q   <= fin ? '0 : cnt_q + 1'b1;
      end
    end
  end

  assign dbg_o = '{state: state_q, cnt: 5'(cnt_q), shreg: shreg_q};

endmodule

// File: tb/tb_fazyrv_spm_ser.sv
// Directed bench for fazyrv_spm_ser: CHUNKSIZE=2 main instance plus CHUNKSIZE=1 and 8 instances.
module tb_fazyrv_spm_ser;
  import fazyrv_spm_pkg::*;

`ifdef FAZYRV_SPM_SER_SEXT_EN
  localparam logic [31:0] RESID_NEG = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] RESID_NEG = 32'h0000_0000;
`endif

  logic     clk;
  logic     rst_n;
  spm_dbg_t d2, d1, d8;
  int       n_tests;
  int       n_fail;
  logic [31:0] exp_q[$];

  fazyrv_spm_ser_if #(.CHUNKSIZE(2)) b2 ();
  fazyrv_spm_ser_if #(.CHUNKSIZE(1)) b1 ();
  fazyrv_spm_ser_if #(.CHUNKSIZE(8)) b8 ();

  fazyrv_spm_ser #(.CHUNKSIZE(2)) u_dut2 (.clk_i(clk), .rst_in(rst_n), .bus(b2), .dbg_o(d2));
  fazyrv_spm_ser #(.CHUNKSIZE(1)) u_dut1 (.clk_i(clk), .rst_in(rst_n), .bus(b1), .dbg_o(d1));
  fazyrv_spm_ser #(.CHUNKSIZE(8)) u_dut8 (.clk_i(clk), .rst_in(rst_n), .bus(b8), .dbg_o(d8));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks for the CHUNKSIZE=2 instance
  task automatic load2(input logic [31:0] word);
    b2.ld_valid_i = 1'b1;
    b2.ld_data_i  = word;
    b2.shft_i     = 1'b0;
    settle();
    check("load_ready", 32'(b2.ld_ready_o), 32'd1);
    tick();
    b2.ld_valid_i = 1'b0;
  endtask

  // consumes the chunks queued in exp_q with shft_i held high
  task automatic drain2(input string tag);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      b2.shft_i = 1'b1;
      settle();
      check({tag, "_ser"}, 32'(b2.ser_o), exp_q.pop_front());
      check({tag, "_last"}, 32'(b2.last_o), 32'(exp_q.size() == 0));
      check({tag, "_valid"}, 32'(b2.ser_valid_o), 32'd1);
      tick();
      i++;
    end
    b2.shft_i = 1'b0;
  endtask

  task automatic push_chunks2(input logic [31:0] word, input int from);
    for (int k = from; k < 16; k++) exp_q.push_back((word >> (2 * k)) & 32'h3);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    b2.ld_valid_i = 1'b0; b2.ld_data_i = '0; b2.shft_i = 1'b0;
    b1.ld_valid_i = 1'b0; b1.ld_data_i = '0; b1.shft_i = 1'b0;
    b8.ld_valid_i = 1'b0; b8.ld_data_i = '0; b8.shft_i = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(b2.ld_ready_o), 32'd1);
    check("rst_valid", 32'(b2.ser_valid_o), 32'd0);
    check("rst_last", 32'(b2.last_o), 32'd0);
    check("rst_ser", 32'(b2.ser_o), 32'd0);
    check("rst_done", 32'(b2.done_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // full word, shft_i held: 0xDEADBEEF -> 3,3,2,3,2,3,3,2,...
    load2(32'hDEAD_BEEF);
    check("t1_first_valid", 32'(b2.ser_valid_o), 32'd1);
    check("t1_first_ser", 32'(b2.ser_o), 32'd3);
    push_chunks2(32'hDEAD_BEEF, 0);
    check("t1_hand0", exp_q[2], 32'd2);
    check("t1_hand7", exp_q[7], 32'd2);
    drain2("t1");
    check("t1_done", 32'(b2.done_o), 32'd1);
    check("t1_idle_valid", 32'(b2.ser_valid_o), 32'd0);
    check("t1_idle_ready", 32'(b2.ld_ready_o), 32'd1);
    check("t1_resid", d2.shreg, RESID_NEG);
    tick();
    check("t1_done_pulse", 32'(b2.done_o), 32'd0);

    // stall: shft_i every other cycle, 32 cycles to completion
    load2(32'h0000_0005);
    for (int c = 0; c < 32; c++) begin
      b2.shft_i = c[0];
      settle();
      check("t2_ser", 32'(b2.ser_o), (c < 4) ? ((c < 2) ? 32'd1 : 32'd1) : 32'd0);
      check("t2_done_early", 32'(b2.done_o), 32'd0);
      tick();
    end
    b2.shft_i = 1'b0;
    check("t2_done", 32'(b2.done_o), 32'd1);
    tick();

    // back-to-back reload during the final shift
    load2(32'h1234_5678);
    for (int i = 0; i < 16; i++) begin
      b2.shft_i = 1'b1;
      if (i == 15) begin
        b2.ld_valid_i = 1'b1;
        b2.ld_data_i  = 32'hCAFE_F00D;
      end
      settle();
      check("t3_ser", 32'(b2.ser_o), (32'h1234_5678 >> (2 * i)) & 32'h3);
      check("t3_valid", 32'(b2.ser_valid_o), 32'd1);
      check("t3_ready", 32'(b2.ld_ready_o), 32'(i == 15));
      tick();
    end
    b2.ld_valid_i = 1'b0;
    b2.shft_i     = 1'b0;
    settle();
    check("t3_done", 32'(b2.done_o), 32'd1);
    check("t3_valid2", 32'(b2.ser_valid_o), 32'd1);
    check("t3_first2", 32'(b2.ser_o), 32'd1);
    check("t3_cnt2", 32'(d2.cnt), 32'd0);
    push_chunks2(32'hCAFE_F00D, 0);
    drain2("t3b");
    check("t3b_done", 32'(b2.done_o), 32'd1);
    tick();

    // reset mid-word
    load2(32'hFFFF_FFFF);
    b2.shft_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    b2.shft_i = 1'b0;
    rst_n = 1'b0;
    settle();
    check("t4_valid", 32'(b2.ser_valid_o), 32'd0);
    check("t4_ready", 32'(b2.ld_ready_o), 32'd1);
    check("t4_done", 32'(b2.done_o), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_no_done", 32'(b2.done_o), 32'd0);
    end

    // shft_i in IDLE is ignored
    b2.shft_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t5_idle_state", 32'(d2.state), 32'(SPM_IDLE));
    check("t5_idle_cnt", 32'(d2.cnt), 32'd0);
    check("t5_idle_valid", 32'(b2.ser_valid_o), 32'd0);
    b2.shft_i = 1'b0;

    // ld_valid_i mid-word is refused
    load2(32'h0F0F_0F0F);
    b2.shft_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    b2.ld_valid_i = 1'b1;
    b2.ld_data_i  = 32'hAAAA_AAAA;
    settle();
    check("t5_refuse", 32'(b2.ld_ready_o), 32'd0);
    check("t5_chunk3", 32'(b2.ser_o), 32'd0);
    tick();
    b2.ld_valid_i = 1'b0;
    check("t5_reg", d2.shreg, 32'h000F_0F0F);
    push_chunks2(32'h0F0F_0F0F, 4);
    drain2("t5");
    check("t5_done", 32'(b2.done_o), 32'd1);
    check("t5_resid", d2.shreg, 32'h0);
    tick();

    // CHUNKSIZE=1 and 8 instances, 0x80000001
    b1.ld_valid_i = 1'b1; b1.ld_data_i = 32'h8000_0001;
    b8.ld_valid_i = 1'b1; b8.ld_data_i = 32'h8000_0001;
    tick();
    b1.ld_valid_i = 1'b0; b8.ld_valid_i = 1'b0;
    b1.shft_i = 1'b1;     b8.shft_i = 1'b1;
    exp_q = '{32'h01, 32'h00, 32'h00, 32'h80};
    for (int i = 0; i < 32; i++) begin
      settle();
      check("t6_ser1", 32'(b1.ser_o), 32'((i == 0) || (i == 31)));
      check("t6_last1", 32'(b1.last_o), 32'(i == 31));
      if (exp_q.size() > 0) begin
        check("t6_ser8", 32'(b8.ser_o), exp_q.pop_front());
        check("t6_last8", 32'(b8.last_o), 32'(exp_q.size() == 0));
      end
      tick();
      if (i == 3) begin
        check("t6_done8", 32'(b8.done_o), 32'd1);
        check("t6_resid8", d8.shreg, RESID_NEG);
        check("t6_idle8", 32'(b8.ser_valid_o), 32'd0);
      end
    end
    check("t6_done1", 32'(b1.done_o), 32'd1);
    check("t6_resid1", d1.shreg, RESID_NEG);
    check("t6_idle1", 32'(b1.ser_valid_o), 32'd0);
    b1.shft_i = 1'b0; b8.shft_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
